// File: rtl/err_pat_dcd_chien_univ_if.sv
// Handshake bundle between the syndrome calculator, the Chien-search error-pattern
// decoder and the data-correction stage.
interface err_pat_dcd_chien_univ_if #(
   parameter int P_D_WIDTH = 16
);
   localparam int LP_M = (P_D_WIDTH <= 21) ? 5 :
                         (P_D_WIDTH <= 51) ? 6 :
                         (P_D_WIDTH <= 113) ? 7 : 8;

   logic                   syn_valid;
   logic                   syn_ready;
   logic [2*LP_M-1:0]      syndromes;
   logic                   msk_valid;
   logic                   msk_ready;
   logic [P_D_WIDTH-1:0]   msk;
   logic [1:0]             err_cnt;
   logic                   uncorr;

   modport master (
      output syn_valid, syndromes, msk_ready,
      input  syn_ready, msk_valid, msk, err_cnt, uncorr
   );

   modport slave (
      input  syn_valid, syndromes, msk_ready,
      output syn_ready, msk_valid, msk, err_cnt, uncorr
   );
endinterface

// File: rtl/err_pat_dcd_chien_univ.sv
// DEC BCH error-pattern decoder: builds a scaled locator from {S3,S1} and runs a
// P_PAR-way parallel Chien search over the data positions of the shortened code.
module err_pat_dcd_chien_univ #(
   parameter int P_D_WIDTH = 16,
   parameter int P_PAR     = 4
) (
   input logic                     clk,
   input logic                     rst,
   err_pat_dcd_chien_univ_if.slave bus
);
   localparam int LP_M = (P_D_WIDTH <= 21) ? 5 :
                         (P_D_WIDTH <= 51) ? 6 :
                         (P_D_WIDTH <= 113) ? 7 : 8;
   localparam int LP_N     = (1 << LP_M) - 1;
   localparam int LP_STEPS = (P_D_WIDTH + P_PAR - 1) / P_PAR;
   localparam int LP_P0    = LP_N - P_D_WIDTH;
   localparam int LP_SW    = $clog2(LP_STEPS + 1);

   // Low-order coefficients of the primitive polynomial; the x^m term is implicit.
   localparam logic [7:0]      POLY8   = (LP_M == 5) ? 8'h05 :
                                         (LP_M == 6) ? 8'h03 :
                                         (LP_M == 7) ? 8'h09 : 8'h1D;
   localparam logic [LP_M-1:0] LP_POLY = POLY8[LP_M-1:0];

   typedef logic [LP_M-1:0] gf_t;

   function automatic gf_t mul_alpha(input gf_t a);
      gf_t r;
      r = {a[LP_M-2:0], 1'b0};
      if (a[LP_M-1])
         r = r ^ LP_POLY;
      return r;
   endfunction

   function automatic gf_t gf_mul(input gf_t a, input gf_t b);
      gf_t r;
      r = '0;
      for (int k = LP_M - 1; k >= 0; k--) begin
         r = mul_alpha(r);
         if (b[k])
            r = r ^ a;
      end
      return r;
   endfunction

   // Squaring is linear over GF(2): XOR of alpha^(2k) for every set bit k.
   function automatic gf_t gf_sqr(input gf_t a);
      gf_t r;
      gf_t pw;
      r  = '0;
      pw = gf_t'(1);
      for (int k = 0; k < LP_M; k++) begin
         if (a[k])
            r = r ^ pw;
         pw = mul_alpha(mul_alpha(pw));
      end
      return r;
   endfunction

   function automatic gf_t alpha_pow_neg(input int k);
      gf_t r;
      int  e;
      r = gf_t'(1);
      e = (LP_N - (k % LP_N)) % LP_N;
      for (int j = 0; j < e; j++)
         r = mul_alpha(r);
      return r;
   endfunction

   localparam gf_t C_P0    = alpha_pow_neg(LP_P0);
   localparam gf_t C_2P0   = alpha_pow_neg(2 * LP_P0);
   localparam gf_t C_STEP1 = alpha_pow_neg(P_PAR);
   localparam gf_t C_STEP2 = alpha_pow_neg(2 * P_PAR);

   typedef enum logic [1:0] {IDLE, CALC, SEARCH, DONE} state_t;

   state_t               state;
   state_t               state_next;
   gf_t                  s1;
   gf_t                  s3;
   gf_t                  s1_sq;
   gf_t                  t0;
   gf_t                  t1;
   gf_t                  t2;
   logic [LP_SW-1:0]     step;
   logic                 last_step;
   logic                 s1_zero;
   logic                 s3_zero;
   logic [P_PAR-1:0]     hit;
   logic [P_D_WIDTH-1:0] step_hits;
   logic [P_D_WIDTH-1:0] acc;
   logic [P_D_WIDTH-1:0] final_mask;
   logic [1:0]           final_cnt;
   logic [P_D_WIDTH-1:0] msk_q;
   logic [1:0]           cnt_q;
   logic                 unc_q;

   assign s1_sq      = gf_sqr(s1);
   assign last_step  = (step == LP_SW'(LP_STEPS - 1));
   assign final_mask = acc | step_hits;

   // Lane i tests position p0 + step*P_PAR + i against the running coefficients.
   for (genvar i = 0; i < P_PAR; i++) begin : g_eval
      localparam gf_t C1 = alpha_pow_neg(i);
      localparam gf_t C2 = alpha_pow_neg(2 * i);
      assign hit[i] = ((t0 ^ gf_mul(t1, C1) ^ gf_mul(t2, C2)) == '0);
   end

   for (genvar j = 0; j < P_D_WIDTH; j++) begin : g_map
      assign step_hits[j] = hit[j % P_PAR] && (step == LP_SW'(j / P_PAR));
   end

   // Popcount saturating at two located errors.
   always_comb begin
      final_cnt = 2'd0;
      for (int j = 0; j < P_D_WIDTH; j++) begin
         if (final_mask[j] && (final_cnt != 2'd2))
            final_cnt = final_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.syn_valid) state_next = CALC;
         CALC:    state_next = SEARCH;
         SEARCH:  if (last_step) state_next = DONE;
         DONE:    if (bus.msk_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.syn_ready = (state == IDLE);
      bus.msk_valid = (state == DONE);
      bus.msk       = msk_q;
      bus.err_cnt   = cnt_q;
      bus.uncorr    = unc_q;
   end

   // Result registers load only on the final search step, so they hold across IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1      <= '0;
         s3      <= '0;
         t0      <= '0;
         t1      <= '0;
         t2      <= '0;
         step    <= '0;
         acc     <= '0;
         s1_zero <= 1'b0;
         s3_zero <= 1'b0;
         msk_q   <= '0;
         cnt_q   <= 2'd0;
         unc_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.syn_valid) begin
                  s1 <= bus.syndromes[LP_M-1:0];
                  s3 <= bus.syndromes[2*LP_M-1:LP_M];
               end
            end
            CALC: begin
               t0      <= s1;
               t1      <= gf_mul(s1_sq, C_P0);
               t2      <= gf_mul(gf_mul(s1, s1_sq) ^ s3, C_2P0);
               s1_zero <= (s1 == '0);
               s3_zero <= (s3 == '0);
               step    <= '0;
               acc     <= '0;
            end
            SEARCH: begin
               t1   <= gf_mul(t1, C_STEP1);
               t2   <= gf_mul(t2, C_STEP2);
               step <= step + 1'b1;
               acc  <= final_mask;
               if (last_step) begin
                  msk_q <= s1_zero ? '0 : final_mask;
                  cnt_q <= s1_zero ? 2'd0 : final_cnt;
                  unc_q <= s1_zero && !s3_zero;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_err_pat_dcd_chien_univ.sv
// Self-checking bench for the Chien-search error-pattern decoder in a GF(2^5)
// 16/4 configuration and a GF(2^8) 239/7 configuration.
module tb_err_pat_dcd_chien_univ;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   err_pat_dcd_chien_univ_if #(.P_D_WIDTH(16))  bus_a ();
   err_pat_dcd_chien_univ_if #(.P_D_WIDTH(239)) bus_b ();

   err_pat_dcd_chien_univ #(.P_D_WIDTH(16), .P_PAR(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   err_pat_dcd_chien_univ #(.P_D_WIDTH(239), .P_PAR(7)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int check_count = 0;
   int pass_count  = 0;
   int sel         = 0;

   logic         sel_syn_ready;
   logic         sel_msk_valid;
   logic [238:0] sel_msk;
   logic [1:0]   sel_cnt;
   logic         sel_unc;

   // View of whichever decoder the current step is exercising.
   always_comb begin
      if (sel == 0) begin
         sel_syn_ready = bus_a.syn_ready;
         sel_msk_valid = bus_a.msk_valid;
         sel_msk       = {223'b0, bus_a.msk};
         sel_cnt       = bus_a.err_cnt;
         sel_unc       = bus_a.uncorr;
      end else begin
         sel_syn_ready = bus_b.syn_ready;
         sel_msk_valid = bus_b.msk_valid;
         sel_msk       = bus_b.msk;
         sel_cnt       = bus_b.err_cnt;
         sel_unc       = bus_b.uncorr;
      end
   end

   // alpha^e in GF(2^m) by repeated multiplication by x modulo the field polynomial.
   function automatic int gfExp(input int m, input int e);
      int n, poly, a;
      n    = (1 << m) - 1;
      poly = (m == 5) ? 'h25 : 'h11D;
      a    = 1;
      for (int k = 0; k < (e % n); k++) begin
         a = a << 1;
         if ((a & (1 << m)) != 0)
            a = a ^ poly;
      end
      return a;
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      check_count++;
      assert (observed === expected) begin
         pass_count++;
      end else begin
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic setInputs(input int which, input logic valid, input logic [15:0] syn,
                            input logic ready);
      if (which == 0) begin
         bus_a.syn_valid = valid;
         bus_a.syndromes = syn[9:0];
         bus_a.msk_ready = ready;
      end else begin
         bus_b.syn_valid = valid;
         bus_b.syndromes = syn;
         bus_b.msk_ready = ready;
      end
   endtask

   // Submit one syndrome word and wait (bounded) for the result, leaving DONE unacknowledged.
   task automatic applyStimulus(input int which, input logic [15:0] syn, input int exp_lat);
      int lat;
      int ready_seen;
      sel = which;
      @(negedge clk);
      checkOutput("ready_before_accept", 256'(sel_syn_ready), 256'(1));
      setInputs(which, 1'b1, syn, 1'b0);
      @(negedge clk);
      setInputs(which, 1'b0, 16'($urandom), 1'b0);
      lat        = 0;
      ready_seen = 0;
      while (!sel_msk_valid && lat < 400) begin
         if (sel_syn_ready)
            ready_seen++;
         @(negedge clk);
         lat++;
      end
      checkOutput("latency", 256'(lat), 256'(exp_lat));
      checkOutput("ready_low_while_busy", 256'(ready_seen), 256'(0));
      checkOutput("ready_low_in_done", 256'(sel_syn_ready), 256'(0));
   endtask

   task automatic releaseResult(input int which);
      setInputs(which, 1'b0, 16'h0, 1'b1);
      @(negedge clk);
      setInputs(which, 1'b0, 16'h0, 1'b0);
      checkOutput("idle_after_ack", 256'(sel_syn_ready), 256'(1));
      checkOutput("valid_low_after_ack", 256'(sel_msk_valid), 256'(0));
   endtask

   task automatic checkResult(input string tag, input logic [238:0] exp_msk,
                              input logic [1:0] exp_cnt, input logic exp_unc);
      checkOutput({tag, "_mask"}, 256'(sel_msk), 256'(exp_msk));
      checkOutput({tag, "_cnt"}, 256'(sel_cnt), 256'(exp_cnt));
      checkOutput({tag, "_uncorr"}, 256'(sel_unc), 256'(exp_unc));
   endtask

   // Random 0/1/2-error job: syndromes from error positions, expected mask from data hits.
   task automatic randomJob(input int which, input int m, input int dwidth, input int steps);
      int           n, p0, nerr, p1, p2, s1, s3, cnt;
      logic [238:0] exp_msk;
      logic [15:0]  syn;
      n       = (1 << m) - 1;
      p0      = n - dwidth;
      nerr    = int'($urandom_range(0, 2));
      s1      = 0;
      s3      = 0;
      exp_msk = '0;
      if ($urandom_range(0, 7) == 0)
         p1 = int'($urandom_range(0, p0 - 1));
      else
         p1 = int'($urandom_range(p0, n - 1));
      p2 = (p1 + 1 + int'($urandom_range(0, n - 2))) % n;
      if (nerr >= 1) begin
         s1 = s1 ^ gfExp(m, p1);
         s3 = s3 ^ gfExp(m, 3 * p1);
         if (p1 >= p0) exp_msk[p1 - p0] = 1'b1;
      end
      if (nerr == 2) begin
         s1 = s1 ^ gfExp(m, p2);
         s3 = s3 ^ gfExp(m, 3 * p2);
         if (p2 >= p0) exp_msk[p2 - p0] = 1'b1;
      end
      cnt = 0;
      for (int k = 0; k < 239; k++)
         if (exp_msk[k]) cnt++;
      syn = 16'((s3 << m) | s1);
      applyStimulus(which, syn, steps + 1);
      checkResult((which == 0) ? "rand_a" : "rand_b", exp_msk, 2'(cnt), 1'b0);
      releaseResult(which);
   endtask

   initial begin
      logic [15:0] syn;
      int          valid_seen;
      rst = 1'b1;
      setInputs(0, 1'b0, 16'h0, 1'b0);
      setInputs(1, 1'b0, 16'h0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      $display("[TB] reset values");
      for (int w = 0; w < 2; w++) begin
         sel = w;
         #1;
         checkOutput("reset_syn_ready", 256'(sel_syn_ready), 256'(1));
         checkOutput("reset_msk_valid", 256'(sel_msk_valid), 256'(0));
         checkResult("reset", '0, 2'd0, 1'b0);
      end

      $display("[TB] directed GF(2^5) jobs");
      applyStimulus(0, 16'h0, 5);
      checkResult("zero", '0, 2'd0, 1'b0);
      releaseResult(0);

      syn = 16'((gfExp(5, 14) << 5) | gfExp(5, 15));
      applyStimulus(0, syn, 5);
      checkResult("single_bit0", 239'h0001, 2'd1, 1'b0);
      releaseResult(0);

      syn = 16'(((gfExp(5, 54) ^ gfExp(5, 90)) << 5) | (gfExp(5, 18) ^ gfExp(5, 30)));
      applyStimulus(0, syn, 5);
      checkResult("double_3_15", 239'h8008, 2'd2, 1'b0);
      releaseResult(0);

      syn = 16'(gfExp(5, 7) << 5);
      applyStimulus(0, syn, 5);
      checkResult("uncorr", '0, 2'd0, 1'b1);
      releaseResult(0);

      $display("[TB] back-pressure");
      syn = 16'((gfExp(5, 14) << 5) | gfExp(5, 15));
      applyStimulus(0, syn, 5);
      for (int c = 0; c < 10; c++) begin
         setInputs(0, 1'b1, 16'h3FF, 1'b0);
         @(negedge clk);
         checkOutput("bp_valid_held", 256'(sel_msk_valid), 256'(1));
         checkOutput("bp_ready_low", 256'(sel_syn_ready), 256'(0));
         checkOutput("bp_mask_stable", 256'(sel_msk), 256'(1));
      end
      releaseResult(0);
      repeat (3) @(negedge clk);
      checkOutput("hold_mask_in_idle", 256'(sel_msk), 256'(1));
      checkOutput("ignored_second_job", 256'(sel_msk_valid), 256'(0));

      $display("[TB] reset during search");
      syn = 16'(((gfExp(5, 54) ^ gfExp(5, 90)) << 5) | (gfExp(5, 18) ^ gfExp(5, 30)));
      setInputs(0, 1'b1, syn, 1'b0);
      @(negedge clk);
      setInputs(0, 1'b0, 16'h0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rst_search_syn_ready", 256'(sel_syn_ready), 256'(1));
      checkOutput("rst_search_msk_valid", 256'(sel_msk_valid), 256'(0));
      checkResult("rst_search", '0, 2'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      valid_seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (sel_msk_valid) valid_seen++;
      end
      checkOutput("dropped_job_no_result", 256'(valid_seen), 256'(0));

      $display("[TB] random GF(2^5) jobs");
      for (int r = 0; r < 20; r++)
         randomJob(0, 5, 16, 4);

      $display("[TB] GF(2^8) 239/7 jobs");
      applyStimulus(1, 16'h0, 36);
      checkResult("zero_b", '0, 2'd0, 1'b0);
      releaseResult(1);
      for (int r = 0; r < 30; r++)
         randomJob(1, 8, 239, 35);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule

// File: doc/err_pat_dcd_chien_univ.md
# err_pat_dcd_chien_univ

Sequential error-pattern decoder for the double-error-correcting (DEC) BCH decoder. It takes the syndrome pair {S3, S1}, forms a scaled error-locator polynomial, and runs a P_PAR-way parallel Chien search over the data positions of the shortened code. It returns a registered correction mask plus error status. It sits between the syndrome calculator and the data-correction XOR stage, and it replaces the table-based decoder. Because it has no ROM, it scales to GF(2^8) and to any data width up to 239.

## Interface
- P_D_WIDTH, 16: data bits protected; legal range 1..239.
- P_PAR, 4: positions evaluated per search cycle; legal range 1..P_D_WIDTH.
- Derived LP_M: smallest m in 5..8 with 2^m-1-2m >= P_D_WIDTH.
- Derived LP_N = 2^LP_M-1.
- Derived LP_STEPS = ceil(P_D_WIDTH/P_PAR).
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- syn_valid_i  in  1  syndrome word valid.
- syn_ready_o  out  1  block can accept a syndrome word.
- syndromes_i  in  2*LP_M  {S3, S1}; S1 in bits [LP_M-1:0], S3 in [2*LP_M-1:LP_M].
- msk_valid_o  out  1  result valid.
- msk_ready_i  in  1  consumer accepts the result.
- msk_o  out  P_D_WIDTH  error mask; bit k set means data bit k is in error.
- err_cnt_o  out  2  number of errors located in data positions (0..2).
- uncorr_o  out  1  uncorrectable pattern detected.

## Operation
- Field polynomials:
  - m=5: x^5+x^2+1
  - m=6: x^6+x+1
  - m=7: x^7+x^3+1
  - m=8: x^8+x^4+x^3+x^2+1
  - alpha is the root x.
- Position map: data bit k corresponds to codeword position p = LP_N-P_D_WIDTH+k. Parity positions are not searched and produce no mask bits.
- Scaled locator: L(x) = S1 + S1^2·x + (S1^3+S3)·x^2.
  - Position p is in error iff L(alpha^-p) = 0.
  - S1^2 uses a linear squarer; S1^3 uses a single general GF multiplier.
- Cases:
  - S1=0 and S3=0: no error. Mask is all zero, err_cnt 0, uncorr 0. The search result is ignored because L is identically 0.
  - S1=0 and S3!=0: uncorr_o=1, mask forced to zero, err_cnt 0.
  - Otherwise: the mask is set from the search. err_cnt_o = popcount of the mask, saturated at 2.
- FSM states IDLE, CALC, SEARCH, DONE:
  - IDLE: syn_ready_o=1. On syn_valid_i, capture syndromes_i and go to CALC.
  - CALC (1 cycle): register T0=S1, T1=S1^2·alpha^-p0, T2=(S1^3+S3)·alpha^-2p0, where p0=LP_N-P_D_WIDTH. Register the case flags. Clear the step counter. Go to SEARCH.
  - SEARCH (LP_STEPS cycles): for i in 0..P_PAR-1, evaluate T0 + T1·alpha^-i + T2·alpha^-2i. Zero results set mask bits step·P_PAR+i; bits at or beyond P_D_WIDTH are discarded. Then update T1 *= alpha^-P_PAR and T2 *= alpha^-2P_PAR. All of these are constant multipliers. After the last step go to DONE.
  - DONE: msk_valid_o=1 and outputs are stable. On msk_ready_i go to IDLE.
- syn_ready_o is high only in IDLE. There is no overlap of jobs.
- msk_valid_o and syn_ready_o are never high in the same cycle.

## Timing
- Reset values: state IDLE, syn_ready_o=1, msk_valid_o=0, msk_o=0, err_cnt_o=0, uncorr_o=0.
- Reset in any state returns immediately to IDLE. Any job in flight is dropped and produces no result.
- Latency: with the accept edge E0, msk_valid_o rises after edge E(LP_STEPS+1). The latency is the same for every syndrome value, including the zero case.
- msk_o, err_cnt_o and uncorr_o change only at the transition into DONE. They hold their values until the next DONE; they are not cleared on leaving DONE.
- Back-pressure: DONE holds indefinitely while msk_ready_i=0. The input is not accepted during this time.
- Throughput: one job per LP_STEPS+3 cycles when msk_ready_i is tied high.
- syndromes_i is sampled only on the accept edge. Later changes to it have no effect.

## Test plan
- P_D_WIDTH=16, P_PAR=4 (m=5, p0=15). Syndromes {0,0}: after 5 cycles, msk_valid_o=1, msk_o=0, err_cnt_o=0, uncorr_o=0.
- Single error on data bit 0: S1=alpha^15, S3=alpha^14. Required: msk_o=16'h0001, err_cnt_o=1.
- Double error on data bits 3 and 15: S1=alpha^18+alpha^30, S3=alpha^54+alpha^90. Required: msk_o=16'h8008, err_cnt_o=2.
- S1=0, S3=alpha^7: required uncorr_o=1, msk_o=0.
- Back-pressure: hold msk_ready_i=0 for 10 cycles. Outputs stay stable, syn_ready_o stays 0, and a second syn_valid_i is ignored until release.
- Reset during SEARCH: outputs return to their reset values and syn_ready_o=1. Repeat with P_D_WIDTH=239, P_PAR=7 (m=8, partial last step) and the mask must match a software reference model for random single and double errors.
